// File: rtl/clk_rate_checker.sv
// clk_rate_checker: samples a divided clock as async data in the sys_clk domain,
// recovers a tick per rising edge, measures every half-period and tracks lock.
// Optional error counter enabled by defining CLK_RATE_CHECKER_ERR_COUNT_EN.
module clk_rate_checker #(
  parameter int EXP_HALF = 50000000,
  parameter int TOL      = 1000,
  parameter int LOCK_CNT = 4,
  parameter int CNT_W    = 32
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic             clk_in,
  output logic             tick,
  output logic             meas_valid,
  output logic [CNT_W-1:0] half_period,
  output logic             locked,
  output logic             lost,
  output logic [15:0]      err_cnt
);

  localparam int GC_W = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] LO      = CNT_W'(EXP_HALF - TOL);
  localparam logic [CNT_W-1:0] HI      = CNT_W'(EXP_HALF + TOL);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, ACQ, LOCKED, LOST} state_t;

  state_t            state, state_nxt;
  logic [GC_W-1:0]   good_cnt, gc_nxt;
  logic [CNT_W-1:0]  cnt, hp_new;
  logic              s1, s2, prev;
  logic              edge_d, rise, meas, in_range, timeout, armed;

  // 2-FF synchroniser plus a delayed copy for edge detection
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
    end else begin
      s1   <= clk_in;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign edge_d   = s2 ^ prev;
  assign rise     = edge_d & s2;
  // cnt holds cycles since the last edge minus one; saturate the result too
  assign hp_new   = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
  assign in_range = (hp_new >= LO) && (hp_new <= HI);
  // the first edge after reset has an unaligned count, so it is not a measurement
  assign meas     = edge_d && (state != IDLE);
  // an edge in the same cycle wins over the timeout
  assign timeout  = armed && !edge_d && (cnt == HI);

  // half-period counter and one-shot timeout arming
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      armed <= 1'b0;
    end else begin
      if (edge_d)              cnt <= '0;
      else if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
      if (edge_d)              armed <= 1'b1;
      else if (timeout)        armed <= 1'b0;
    end
  end

  // lock state machine: next state and consecutive-good counter
  always_comb begin
    state_nxt = state;
    gc_nxt    = good_cnt;
    case (state)
      IDLE: begin
        if (edge_d) begin
          state_nxt = ACQ;
          gc_nxt    = '0;
        end
      end
      ACQ: begin
        if (meas && in_range) begin
          if (good_cnt == GC_W'(LOCK_CNT - 1)) begin
            state_nxt = LOCKED;
            gc_nxt    = '0;
          end else begin
            gc_nxt = good_cnt + GC_W'(1);
          end
        end else if (meas || timeout) begin
          gc_nxt = '0;
        end
      end
      LOCKED: begin
        if ((meas && !in_range) || timeout) state_nxt = LOST;
      end
      LOST: begin
        // the edge leaving LOST is not trusted as a measurement
        if (edge_d) begin
          state_nxt = ACQ;
          gc_nxt    = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        gc_nxt    = '0;
      end
    endcase
  end

  // state register
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      good_cnt <= '0;
    end else begin
      state    <= state_nxt;
      good_cnt <= gc_nxt;
    end
  end

  // registered outputs; status flags follow the next state so they line up with meas_valid
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      tick        <= 1'b0;
      meas_valid  <= 1'b0;
      half_period <= '0;
      locked      <= 1'b0;
      lost        <= 1'b0;
    end else begin
      tick       <= rise;
      meas_valid <= meas;
      if (meas) half_period <= hp_new;
      locked     <= (state_nxt == LOCKED);
      lost       <= (state_nxt == LOST);
    end
  end

`ifdef CLK_RATE_CHECKER_ERR_COUNT_EN
  logic err_ev;
  assign err_ev = ((state == LOCKED) && ((meas && !in_range) || timeout)) ||
                  ((state == LOST) && timeout);

  // saturating error counter, cleared only by reset
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst)                                err_cnt <= 16'h0000;
    else if (err_ev && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'h0001;
  end
`else
  assign err_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_clk_rate_checker.sv
// Directed bench for clk_rate_checker: vector table for the edge stream,
// hand sequences for reset, stall timeout, saturation and async reset.
module tb_clk_rate_checker;

  localparam int CNT_W = 8;
`ifdef CLK_RATE_CHECKER_ERR_COUNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic             sys_clk = 1'b0;
  logic             rst     = 1'b1;
  logic             clk_in  = 1'b0;
  logic             tick, meas_valid, locked, lost;
  logic [CNT_W-1:0] half_period;
  logic [15:0]      err_cnt;

  int n_run  = 0;
  int n_fail = 0;

  clk_rate_checker #(.EXP_HALF(10), .TOL(1), .LOCK_CNT(4), .CNT_W(CNT_W)) dut (
    .sys_clk(sys_clk), .rst(rst), .clk_in(clk_in), .tick(tick),
    .meas_valid(meas_valid), .half_period(half_period), .locked(locked),
    .lost(lost), .err_cnt(err_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic             lvl;
    int               hold;
    logic             mv;
    logic [CNT_W-1:0] hp;
    logic             lk;
    logic             ls;
    logic [15:0]      err;
  } vec_t;

  vec_t tbl[17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    @(negedge sys_clk);
  endtask

  function automatic logic [15:0] exp_err(input logic [15:0] e);
    return ERR_EN ? e : 16'h0000;
  endfunction

  task automatic chk_all_zero(input string nm);
    chk({nm, "_tick"}, {31'd0, tick}, 0);
    chk({nm, "_mv"}, {31'd0, meas_valid}, 0);
    chk({nm, "_hp"}, {24'd0, half_period}, 0);
    chk({nm, "_locked"}, {31'd0, locked}, 0);
    chk({nm, "_lost"}, {31'd0, lost}, 0);
    chk({nm, "_err"}, {16'd0, err_cnt}, 0);
  endtask

  initial begin
    int pulses;
    // edge level, hold, exp meas_valid, exp half_period, locked, lost, err (counter on)
    tbl[0]  = '{1'b1, 10, 1'b0, 8'd0,  1'b0, 1'b0, 16'd0};
    tbl[1]  = '{1'b0, 10, 1'b1, 8'd10, 1'b0, 1'b0, 16'd0};
    tbl[2]  = '{1'b1, 10, 1'b1, 8'd10, 1'b0, 1'b0, 16'd0};
    tbl[3]  = '{1'b0, 10, 1'b1, 8'd10, 1'b0, 1'b0, 16'd0};
    tbl[4]  = '{1'b1, 10, 1'b1, 8'd10, 1'b1, 1'b0, 16'd0};
    tbl[5]  = '{1'b0,  9, 1'b1, 8'd10, 1'b1, 1'b0, 16'd0};
    tbl[6]  = '{1'b1, 11, 1'b1, 8'd9,  1'b1, 1'b0, 16'd0};
    tbl[7]  = '{1'b0,  9, 1'b1, 8'd11, 1'b1, 1'b0, 16'd0};
    tbl[8]  = '{1'b1, 11, 1'b1, 8'd9,  1'b1, 1'b0, 16'd0};
    tbl[9]  = '{1'b0, 12, 1'b1, 8'd11, 1'b1, 1'b0, 16'd0};
    tbl[10] = '{1'b1, 10, 1'b1, 8'd12, 1'b0, 1'b1, 16'd1};
    tbl[11] = '{1'b0, 10, 1'b1, 8'd10, 1'b0, 1'b0, 16'd1};
    tbl[12] = '{1'b1, 10, 1'b1, 8'd10, 1'b0, 1'b0, 16'd1};
    tbl[13] = '{1'b0, 10, 1'b1, 8'd10, 1'b0, 1'b0, 16'd1};
    tbl[14] = '{1'b1, 10, 1'b1, 8'd10, 1'b0, 1'b0, 16'd1};
    tbl[15] = '{1'b0, 10, 1'b1, 8'd10, 1'b1, 1'b0, 16'd1};
    tbl[16] = '{1'b1,  3, 1'b1, 8'd10, 1'b1, 1'b0, 16'd1};

    // reset held while clk_in toggles
    @(negedge sys_clk);
    for (int i = 0; i < 6; i++) begin
      clk_in = ~clk_in;
      step();
    end
    chk_all_zero("rst_hold");
    clk_in = 1'b0;
    step();
    rst = 1'b0;

    // idle: no edges, the IDLE timeout must be ignored
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      pulses += int'(tick) + int'(meas_valid) + int'(lost) + int'(locked);
    end
    chk("idle_activity", pulses, 0);

    // table-driven edge stream: acquire, jitter, bad period, relock
    for (int i = 0; i < 17; i++) begin
      clk_in = tbl[i].lvl;
      for (int c = 1; c <= tbl[i].hold; c++) begin
        step();
        chk($sformatf("v%0d_c%0d_tick", i, c), {31'd0, tick}, {31'd0, (c == 3) && tbl[i].lvl});
        chk($sformatf("v%0d_c%0d_mv", i, c), {31'd0, meas_valid}, {31'd0, (c == 3) && tbl[i].mv});
        if (c == 3) begin
          chk($sformatf("v%0d_hp", i), {24'd0, half_period}, {24'd0, tbl[i].hp});
          chk($sformatf("v%0d_locked", i), {31'd0, locked}, {31'd0, tbl[i].lk});
          chk($sformatf("v%0d_lost", i), {31'd0, lost}, {31'd0, tbl[i].ls});
          chk($sformatf("v%0d_err", i), {16'd0, err_cnt}, {16'd0, exp_err(tbl[i].err)});
        end
      end
    end

    // stall with clk_in high: timeout once cnt reaches EXP_HALF+TOL
    for (int c = 4; c <= 15; c++) begin
      step();
      if (c == 14) begin
        chk("stall_pre_lost", {31'd0, lost}, 0);
        chk("stall_pre_locked", {31'd0, locked}, 1);
      end
    end
    chk("stall_lost", {31'd0, lost}, 1);
    chk("stall_locked", {31'd0, locked}, 0);
    chk("stall_mv", {31'd0, meas_valid}, 0);
    chk("stall_hp", {24'd0, half_period}, 10);
    chk("stall_err", {16'd0, err_cnt}, {16'd0, exp_err(16'd2)});

    // long stall: counter saturates, no further timeouts or measurements
    pulses = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      pulses += int'(meas_valid) + int'(tick);
    end
    chk("long_stall_pulses", pulses, 0);
    chk("long_stall_lost", {31'd0, lost}, 1);
    chk("long_stall_err", {16'd0, err_cnt}, {16'd0, exp_err(16'd2)});

    // relock: first edge leaves LOST with a saturated, ignored measurement
    for (int j = 0; j < 5; j++) begin
      clk_in = (j % 2 == 1);
      for (int c = 1; c <= 10; c++) begin
        step();
        if (c == 3) begin
          chk($sformatf("relock%0d_mv", j), {31'd0, meas_valid}, 1);
          chk($sformatf("relock%0d_hp", j), {24'd0, half_period}, (j == 0) ? 255 : 10);
          chk($sformatf("relock%0d_lost", j), {31'd0, lost}, 0);
          chk($sformatf("relock%0d_locked", j), {31'd0, locked}, {31'd0, j == 4});
        end
      end
    end
    chk("relock_err", {16'd0, err_cnt}, {16'd0, exp_err(16'd2)});

    // asynchronous reset while locked, between clock edges
    #2 rst = 1'b1;
    #1 chk_all_zero("async_rst");
    step();
    rst = 1'b0;
    step();
    chk_all_zero("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
